// File: rtl/segment_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : segment_accumulator
// Description : Sums and counts unsigned samples per segment. Each closed
//               segment is presented as a dividend/divisor pair with a start
//               pulse for the downstream mean divider.
// Revision    : 1.0 - initial release
// ============================================================================
module segment_accumulator #(
    parameter int DATA_W  = 8,
    parameter int COUNT_W = 20
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [DATA_W-1:0]          DataIn,
    input  logic                       ValidIn,
    input  logic                       LastIn,
    input  logic                       Clear,
    input  logic [COUNT_W-1:0]         MaxCount,
    output logic [DATA_W+COUNT_W-1:0]  SumOut,
    output logic [COUNT_W-1:0]         CountOut,
    output logic                       StartOut
);

    localparam int SUM_W = DATA_W + COUNT_W;

    // Sum width covers (2^COUNT_W-1) maximum-valued samples, so it never wraps.
    logic [SUM_W-1:0]   acc_sum_q, acc_sum_d;
    logic [COUNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [SUM_W-1:0]   sum_out_q, sum_out_d;
    logic [COUNT_W-1:0] cnt_out_q, cnt_out_d;
    logic               start_q,   start_d;

    logic [SUM_W-1:0]   n_sum;
    logic [COUNT_W-1:0] n_cnt;
    logic               accept;
    logic               hit_max;
    logic               close;

    always_comb begin
        n_sum   = acc_sum_q + {{COUNT_W{1'b0}}, DataIn};
        n_cnt   = acc_cnt_q + {{(COUNT_W-1){1'b0}}, 1'b1};
        accept  = ValidIn & ~Clear;
        // >= rather than == so lowering MaxCount mid-segment closes at once.
        hit_max = (MaxCount != '0) && (n_cnt >= MaxCount);
        close   = accept & (LastIn | hit_max | (&n_cnt));
    end

    always_comb begin
        acc_sum_d = acc_sum_q;
        acc_cnt_d = acc_cnt_q;
        sum_out_d = sum_out_q;
        cnt_out_d = cnt_out_q;
        start_d   = 1'b0;
        if (Clear) begin
            acc_sum_d = '0;
            acc_cnt_d = '0;
        end else if (close) begin
            sum_out_d = n_sum;
            cnt_out_d = n_cnt;
            start_d   = 1'b1;
            acc_sum_d = '0;
            acc_cnt_d = '0;
        end else if (accept) begin
            acc_sum_d = n_sum;
            acc_cnt_d = n_cnt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_sum_q <= '0;
            acc_cnt_q <= '0;
            sum_out_q <= '0;
            cnt_out_q <= '0;
            start_q   <= 1'b0;
        end else begin
            acc_sum_q <= acc_sum_d;
            acc_cnt_q <= acc_cnt_d;
            sum_out_q <= sum_out_d;
            cnt_out_q <= cnt_out_d;
            start_q   <= start_d;
        end
    end

    assign SumOut   = sum_out_q;
    assign CountOut = cnt_out_q;
    assign StartOut = start_q;

endmodule
`default_nettype wire
